// File: rtl/prf_free_list.sv
// Free list of physical register tags for a 2-wide rename stage.
// A circular FIFO hands out the oldest free tags, reclaims retired tags, and rewinds on flush.
module prf_free_list #(
  parameter int PRF_SIZE = 64,
  parameter int ARF_SIZE = 32,
  parameter int PRF_IDX  = 6
) (
  input  logic               i_clock,
  input  logic               i_reset,          // asynchronous, active-low
  input  logic               i_used_1,
  input  logic               i_used_2,
  input  logic               i_retire_valid_1,
  input  logic [PRF_IDX-1:0] i_retire_old_1,
  input  logic               i_retire_valid_2,
  input  logic [PRF_IDX-1:0] i_retire_old_2,
  input  logic               i_flush,
  output logic [PRF_IDX-1:0] o_free_reg_1,
  output logic [PRF_IDX-1:0] o_free_reg_2,
  output logic               o_free_valid_1,
  output logic               o_free_valid_2,
  output logic [PRF_IDX:0]   o_free_count
);

  localparam int D     = PRF_SIZE - ARF_SIZE;
  localparam int PTR_W = $clog2(D);
  localparam int CNT_W = PRF_IDX + 1;

  typedef logic [PTR_W-1:0] ptr_t;

  // Modular add that stays correct even when D is not a power of two.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [1:0] n);
    logic [PTR_W:0] s;
    s = {1'b0, p} + (PTR_W+1)'(n);
    if (s >= (PTR_W+1)'(D)) s = s - (PTR_W+1)'(D);
    return s[PTR_W-1:0];
  endfunction

  logic [PRF_IDX-1:0] r_fifo [D];
  ptr_t               r_head;
  ptr_t               r_tail;
  logic [CNT_W-1:0]   r_count;

  logic [1:0]         w_alloc_req;
  logic [1:0]         w_alloc;
  logic [1:0]         w_freed;
  logic [CNT_W-1:0]   w_req_ext;
  logic [CNT_W:0]     w_count_sum;
  ptr_t               w_head_next;
  ptr_t               w_tail_next;
  ptr_t               w_wr_idx_2;

  assign w_alloc_req = {1'b0, i_used_1} + {1'b0, i_used_2};
  assign w_freed     = {1'b0, i_retire_valid_1} + {1'b0, i_retire_valid_2};
  assign w_req_ext   = CNT_W'(w_alloc_req);

  // Requests beyond the available count are dropped; flush cancels allocation entirely.
  always_comb begin
    w_alloc = w_alloc_req;
    if (i_flush)                   w_alloc = '0;
    else if (w_req_ext > r_count)  w_alloc = r_count[1:0];
  end

  assign w_head_next = ptr_add(r_head, w_alloc);
  assign w_tail_next = ptr_add(r_tail, w_freed);
  // A lone slot-2 retirement lands at tail, otherwise right behind slot 1.
  assign w_wr_idx_2  = ptr_add(r_tail, {1'b0, i_retire_valid_1});
  assign w_count_sum = {1'b0, r_count} - (CNT_W+1)'(w_alloc) + (CNT_W+1)'(w_freed);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      // NOTE: the array is reset, not left uninitialised: its reset contents ARE the initial free list.
      for (int i = 0; i < D; i++) r_fifo[i] <= PRF_IDX'(ARF_SIZE + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= CNT_W'(D);
    end else begin
      // NOTE: non-blocking assignments so every update here sees the pre-edge state.
      if (i_retire_valid_1) r_fifo[r_tail]     <= i_retire_old_1;
      if (i_retire_valid_2) r_fifo[w_wr_idx_2] <= i_retire_old_2;
      r_tail <= w_tail_next;
      if (i_flush) begin
        // Tail marks the committed head, so rewinding to it frees every speculative tag.
        r_head  <= w_tail_next;
        r_count <= CNT_W'(D);
      end else begin
        r_head  <= w_head_next;
        r_count <= w_count_sum[CNT_W-1:0];
      end
    end
  end

  assign o_free_reg_1   = r_fifo[r_head];
  assign o_free_reg_2   = r_fifo[ptr_add(r_head, 2'd1)];
  assign o_free_valid_1 = (r_count >= CNT_W'(1));
  assign o_free_valid_2 = (r_count >= CNT_W'(2));
  assign o_free_count   = r_count;

  a_no_over_alloc : assert property (@(posedge i_clock) disable iff (!i_reset)
    !i_flush |-> (w_req_ext <= r_count));

  a_no_overflow : assert property (@(posedge i_clock) disable iff (!i_reset)
    !i_flush |-> (w_count_sum <= (CNT_W+1)'(D)));

endmodule
